// File: rtl/timing_generator.sv
// T-state sequencer: one-hot strobes t0..t5 for the control unit, per-opcode
// instruction length, sticky HALT and a retired-instruction counter.
// Optional single-step qualifier on advance: define TIMING_SINGLE_STEP_EN.
module timing_generator #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic [3:0]       opcode,
`ifdef TIMING_SINGLE_STEP_EN
    input  logic             step,
    input  logic             step_mode,
`endif
    output logic             t0,
    output logic             t1,
    output logic             t2,
    output logic             t3,
    output logic             t4,
    output logic             t5,
    output logic             last_t,
    output logic             halted,
    output logic [CNT_W-1:0] instr_count
);

    typedef enum logic [2:0] {
        T0 = 3'd0,
        T1 = 3'd1,
        T2 = 3'd2,
        T3 = 3'd3,
        T4 = 3'd4,
        T5 = 3'd5
    } tstate_e;

    localparam logic [3:0]       OP_MOV  = 4'b0000;
    localparam logic [3:0]       OP_ADD  = 4'b0011;
    localparam logic [3:0]       OP_SUB  = 4'b0100;
    localparam logic [3:0]       OP_HALT = 4'b1111;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    tstate_e          state, state_nx;
    logic [5:0]       tvec, tvec_nx;
    logic             halted_nx;
    logic [CNT_W-1:0] count_nx;
    logic             long_op;
    logic             adv;
    logic             step_ok;

`ifdef TIMING_SINGLE_STEP_EN
    logic step_s1, step_s2, step_s3, step_pulse;

    // step is asynchronous to clk: two-flop sync, then one pulse per rising edge
    always_ff @(posedge clk) begin
        if (reset) begin
            step_s1    <= 1'b0;
            step_s2    <= 1'b0;
            step_s3    <= 1'b0;
            step_pulse <= 1'b0;
        end else begin
            step_s1    <= step;
            step_s2    <= step_s1;
            step_s3    <= step_s2;
            step_pulse <= step_s2 & ~step_s3;
        end
    end

    assign step_ok = ~step_mode | step_pulse;
`else
    assign step_ok = 1'b1;
`endif

    assign long_op = (opcode == OP_MOV) | (opcode == OP_ADD) | (opcode == OP_SUB);

    // Strobes are zero while halted, so last_t drops with them
    assign last_t = (tvec[3] & ~long_op) | tvec[5];
    assign adv    = run & ~halted & step_ok;

    assign {t5, t4, t3, t2, t1, t0} = tvec;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= T0;
            tvec        <= 6'b000001;
            halted      <= 1'b0;
            instr_count <= '0;
        end else begin
            state       <= state_nx;
            tvec        <= tvec_nx;
            halted      <= halted_nx;
            instr_count <= count_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        tvec_nx   = tvec;
        halted_nx = halted;
        count_nx  = instr_count;

        if (adv) begin
            if (!last_t) begin
                case (state)
                    T0:      state_nx = T1;
                    T1:      state_nx = T2;
                    T2:      state_nx = T3;
                    T3:      state_nx = T4;
                    T4:      state_nx = T5;
                    default: state_nx = T0;
                endcase
            end else begin
                count_nx = instr_count + CNT_ONE;
                // HALT retires but freezes the index where it stopped
                if (state == T3 && opcode == OP_HALT)
                    halted_nx = 1'b1;
                else
                    state_nx = T0;
            end

            if (halted_nx) begin
                tvec_nx = 6'b000000;
            end else begin
                case (state_nx)
                    T0:      tvec_nx = 6'b000001;
                    T1:      tvec_nx = 6'b000010;
                    T2:      tvec_nx = 6'b000100;
                    T3:      tvec_nx = 6'b001000;
                    T4:      tvec_nx = 6'b010000;
                    T5:      tvec_nx = 6'b100000;
                    default: tvec_nx = 6'b000001;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_timing_generator.sv
// Scoreboard bench for timing_generator: each test queues per-cycle stimulus
// with the outputs expected after that clock edge.
module tb_timing_generator;
    localparam int CNT_W = 8;

    typedef struct packed {
        logic             rst;
        logic             run;
        logic [3:0]       op;
        logic             stp;
        logic [5:0]       t;
        logic             lt;
        logic             h;
        logic [CNT_W-1:0] c;
    } vec_t;

    logic             clk = 1'b0;
    logic             reset;
    logic             run;
    logic [3:0]       opcode;
    logic             t0, t1, t2, t3, t4, t5;
    logic             last_t;
    logic             halted;
    logic [CNT_W-1:0] instr_count;
`ifdef TIMING_SINGLE_STEP_EN
    logic             step;
    logic             step_mode;
`endif

    logic [CNT_W+7:0] obs;
    assign obs = {t5, t4, t3, t2, t1, t0, last_t, halted, instr_count};

    int   n_cmp = 0;
    int   n_bad = 0;
    vec_t sb[$];

    always #5 clk = ~clk;

    timing_generator #(.CNT_W(CNT_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .run         (run),
        .opcode      (opcode),
`ifdef TIMING_SINGLE_STEP_EN
        .step        (step),
        .step_mode   (step_mode),
`endif
        .t0          (t0),
        .t1          (t1),
        .t2          (t2),
        .t3          (t3),
        .t4          (t4),
        .t5          (t5),
        .last_t      (last_t),
        .halted      (halted),
        .instr_count (instr_count)
    );

    function automatic vec_t mk(input logic rst, input logic rn, input logic [3:0] op,
                                input logic stp, input logic [5:0] t, input logic lt,
                                input logic h, input logic [CNT_W-1:0] c);
        vec_t v;
        v.rst = rst; v.run = rn; v.op = op; v.stp = stp;
        v.t = t; v.lt = lt; v.h = h; v.c = c;
        return v;
    endfunction

    task automatic test_reset();
        vec_t q[$];
        vec_t e;
        q.push_back(mk(1, 0, 4'b0000, 0, 6'b000001, 0, 0, 0));
        q.push_back(mk(1, 1, 4'b1110, 0, 6'b000001, 0, 0, 0));
        q.push_back(mk(0, 0, 4'b1110, 0, 6'b000001, 0, 0, 0));
        q.push_back(mk(0, 0, 4'b0000, 0, 6'b000001, 0, 0, 0));
        foreach (q[i]) begin
            reset = q[i].rst; run = q[i].run; opcode = q[i].op;
            sb.push_back(q[i]);
            @(posedge clk); #1;
            e = sb.pop_front();
            n_cmp++;
            if (obs !== {e.t, e.lt, e.h, e.c}) begin
                n_bad++;
                $display("FAIL reset[%0d]: got %b want %b", i, obs, {e.t, e.lt, e.h, e.c});
            end
        end
    endtask

    task automatic test_mov();
        vec_t q[$];
        vec_t e;
        q.push_back(mk(1, 0, 4'b0000, 0, 6'b000001, 0, 0, 0));
        q.push_back(mk(0, 1, 4'b0000, 0, 6'b000010, 0, 0, 0));
        q.push_back(mk(0, 1, 4'b0000, 0, 6'b000100, 0, 0, 0));
        q.push_back(mk(0, 1, 4'b0000, 0, 6'b001000, 0, 0, 0));
        q.push_back(mk(0, 1, 4'b0000, 0, 6'b010000, 0, 0, 0));
        q.push_back(mk(0, 1, 4'b0000, 0, 6'b100000, 1, 0, 0));
        q.push_back(mk(0, 1, 4'b0000, 0, 6'b000001, 0, 0, 1));
        q.push_back(mk(0, 1, 4'b0000, 0, 6'b000010, 0, 0, 1));
        foreach (q[i]) begin
            reset = q[i].rst; run = q[i].run; opcode = q[i].op;
            sb.push_back(q[i]);
            @(posedge clk); #1;
            e = sb.pop_front();
            n_cmp++;
            if (obs !== {e.t, e.lt, e.h, e.c}) begin
                n_bad++;
                $display("FAIL mov[%0d]: got %b want %b", i, obs, {e.t, e.lt, e.h, e.c});
            end
        end
    endtask

    task automatic test_out();
        vec_t q[$];
        vec_t e;
        q.push_back(mk(1, 0, 4'b1110, 0, 6'b000001, 0, 0, 0));
        for (int k = 0; k < 2; k++) begin
            q.push_back(mk(0, 1, 4'b1110, 0, 6'b000010, 0, 0, CNT_W'(k)));
            q.push_back(mk(0, 1, 4'b1110, 0, 6'b000100, 0, 0, CNT_W'(k)));
            q.push_back(mk(0, 1, 4'b1110, 0, 6'b001000, 1, 0, CNT_W'(k)));
            q.push_back(mk(0, 1, 4'b1110, 0, 6'b000001, 0, 0, CNT_W'(k + 1)));
        end
        foreach (q[i]) begin
            reset = q[i].rst; run = q[i].run; opcode = q[i].op;
            sb.push_back(q[i]);
            @(posedge clk); #1;
            e = sb.pop_front();
            n_cmp++;
            if (obs !== {e.t, e.lt, e.h, e.c}) begin
                n_bad++;
                $display("FAIL out[%0d]: got %b want %b", i, obs, {e.t, e.lt, e.h, e.c});
            end
        end
    endtask

    task automatic test_halt();
        vec_t q[$];
        vec_t e;
        q.push_back(mk(1, 0, 4'b1111, 0, 6'b000001, 0, 0, 0));
        q.push_back(mk(0, 1, 4'b1111, 0, 6'b000010, 0, 0, 0));
        q.push_back(mk(0, 1, 4'b1111, 0, 6'b000100, 0, 0, 0));
        q.push_back(mk(0, 1, 4'b1111, 0, 6'b001000, 1, 0, 0));
        for (int k = 0; k < 11; k++)
            q.push_back(mk(0, 1, (k % 2 == 0) ? 4'b1111 : 4'b0000, 0, 6'b000000, 0, 1, 1));
        q.push_back(mk(1, 1, 4'b1111, 0, 6'b000001, 0, 0, 0));
        q.push_back(mk(0, 0, 4'b1111, 0, 6'b000001, 0, 0, 0));
        foreach (q[i]) begin
            reset = q[i].rst; run = q[i].run; opcode = q[i].op;
            sb.push_back(q[i]);
            @(posedge clk); #1;
            e = sb.pop_front();
            n_cmp++;
            if (obs !== {e.t, e.lt, e.h, e.c}) begin
                n_bad++;
                $display("FAIL halt[%0d]: got %b want %b", i, obs, {e.t, e.lt, e.h, e.c});
            end
        end
    endtask

    // run=0 stalls during t2 and t3 of an ADD; opcode flips during t4 only
    task automatic test_run_hold();
        vec_t q[$];
        vec_t e;
        q.push_back(mk(1, 0, 4'b0011, 0, 6'b000001, 0, 0, 0));
        q.push_back(mk(0, 1, 4'b0011, 0, 6'b000010, 0, 0, 0));
        q.push_back(mk(0, 1, 4'b0011, 0, 6'b000100, 0, 0, 0));
        for (int k = 0; k < 3; k++)
            q.push_back(mk(0, 0, 4'b0011, 0, 6'b000100, 0, 0, 0));
        q.push_back(mk(0, 1, 4'b0011, 0, 6'b001000, 0, 0, 0));
        q.push_back(mk(0, 0, 4'b0011, 0, 6'b001000, 0, 0, 0));
        q.push_back(mk(0, 1, 4'b0011, 0, 6'b010000, 0, 0, 0));
        q.push_back(mk(0, 1, 4'b1110, 0, 6'b100000, 1, 0, 0));
        q.push_back(mk(0, 0, 4'b0011, 0, 6'b100000, 1, 0, 0));
        q.push_back(mk(0, 1, 4'b0011, 0, 6'b000001, 0, 0, 1));
        foreach (q[i]) begin
            reset = q[i].rst; run = q[i].run; opcode = q[i].op;
            sb.push_back(q[i]);
            @(posedge clk); #1;
            e = sb.pop_front();
            n_cmp++;
            if (obs !== {e.t, e.lt, e.h, e.c}) begin
                n_bad++;
                $display("FAIL run_hold[%0d]: got %b want %b", i, obs, {e.t, e.lt, e.h, e.c});
            end
        end
    endtask

    // 256 OUTs wrap the counter; then reset in t4 of a SUB clears it
    task automatic test_wrap_reset();
        vec_t q[$];
        vec_t e;
        q.push_back(mk(1, 0, 4'b1110, 0, 6'b000001, 0, 0, 0));
        for (int k = 0; k < 257; k++) begin
            q.push_back(mk(0, 1, 4'b1110, 0, 6'b000010, 0, 0, CNT_W'(k)));
            q.push_back(mk(0, 1, 4'b1110, 0, 6'b000100, 0, 0, CNT_W'(k)));
            q.push_back(mk(0, 1, 4'b1110, 0, 6'b001000, 1, 0, CNT_W'(k)));
            q.push_back(mk(0, 1, 4'b1110, 0, 6'b000001, 0, 0, CNT_W'(k + 1)));
        end
        q.push_back(mk(0, 1, 4'b0100, 0, 6'b000010, 0, 0, 1));
        q.push_back(mk(0, 1, 4'b0100, 0, 6'b000100, 0, 0, 1));
        q.push_back(mk(0, 1, 4'b0100, 0, 6'b001000, 0, 0, 1));
        q.push_back(mk(0, 1, 4'b0100, 0, 6'b010000, 0, 0, 1));
        q.push_back(mk(1, 1, 4'b0100, 0, 6'b000001, 0, 0, 0));
        q.push_back(mk(0, 1, 4'b0100, 0, 6'b000010, 0, 0, 0));
        foreach (q[i]) begin
            reset = q[i].rst; run = q[i].run; opcode = q[i].op;
            sb.push_back(q[i]);
            @(posedge clk); #1;
            e = sb.pop_front();
            n_cmp++;
            if (obs !== {e.t, e.lt, e.h, e.c}) begin
                n_bad++;
                $display("FAIL wrap_reset[%0d]: got %b want %b", i, obs, {e.t, e.lt, e.h, e.c});
            end
        end
    endtask

    task automatic test_back_to_back();
        vec_t q[$];
        vec_t e;
        q.push_back(mk(1, 0, 4'b1110, 0, 6'b000001, 0, 0, 0));
        q.push_back(mk(0, 1, 4'b1110, 0, 6'b000010, 0, 0, 0));
        q.push_back(mk(0, 1, 4'b1110, 0, 6'b000100, 0, 0, 0));
        q.push_back(mk(0, 1, 4'b1110, 0, 6'b001000, 1, 0, 0));
        q.push_back(mk(0, 1, 4'b1110, 0, 6'b000001, 0, 0, 1));
        for (int k = 0; k < 2; k++) begin
            q.push_back(mk(0, 1, k ? 4'b0100 : 4'b0000, 0, 6'b000010, 0, 0, CNT_W'(k + 1)));
            q.push_back(mk(0, 1, k ? 4'b0100 : 4'b0000, 0, 6'b000100, 0, 0, CNT_W'(k + 1)));
            q.push_back(mk(0, 1, k ? 4'b0100 : 4'b0000, 0, 6'b001000, 0, 0, CNT_W'(k + 1)));
            q.push_back(mk(0, 1, k ? 4'b0100 : 4'b0000, 0, 6'b010000, 0, 0, CNT_W'(k + 1)));
            q.push_back(mk(0, 1, k ? 4'b0100 : 4'b0000, 0, 6'b100000, 1, 0, CNT_W'(k + 1)));
            q.push_back(mk(0, 1, k ? 4'b0100 : 4'b0000, 0, 6'b000001, 0, 0, CNT_W'(k + 2)));
        end
        q.push_back(mk(0, 1, 4'b1111, 0, 6'b000010, 0, 0, 3));
        q.push_back(mk(0, 1, 4'b1111, 0, 6'b000100, 0, 0, 3));
        q.push_back(mk(0, 1, 4'b1111, 0, 6'b001000, 1, 0, 3));
        q.push_back(mk(0, 1, 4'b1111, 0, 6'b000000, 0, 1, 4));
        q.push_back(mk(0, 1, 4'b0011, 0, 6'b000000, 0, 1, 4));
        foreach (q[i]) begin
            reset = q[i].rst; run = q[i].run; opcode = q[i].op;
            sb.push_back(q[i]);
            @(posedge clk); #1;
            e = sb.pop_front();
            n_cmp++;
            if (obs !== {e.t, e.lt, e.h, e.c}) begin
                n_bad++;
                $display("FAIL back_to_back[%0d]: got %b want %b", i, obs, {e.t, e.lt, e.h, e.c});
            end
        end
    endtask

`ifdef TIMING_SINGLE_STEP_EN
    // Each press shows up as an advance on the fourth edge after it is applied
    task automatic test_step();
        vec_t q[$];
        vec_t e;
        logic [5:0] tk;
        q.push_back(mk(1, 0, 4'b0000, 0, 6'b000001, 0, 0, 0));
        q.push_back(mk(0, 1, 4'b0000, 0, 6'b000001, 0, 0, 0));
        q.push_back(mk(0, 1, 4'b0000, 0, 6'b000001, 0, 0, 0));
        tk = 6'b000001;
        for (int p = 0; p < 3; p++) begin
            q.push_back(mk(0, 1, 4'b0000, 1, tk, 0, 0, 0));
            q.push_back(mk(0, 1, 4'b0000, 0, tk, 0, 0, 0));
            q.push_back(mk(0, 1, 4'b0000, 0, tk, 0, 0, 0));
            tk = tk << 1;
            q.push_back(mk(0, 1, 4'b0000, 0, tk, 0, 0, 0));
        end
        for (int k = 0; k < 20; k++)
            q.push_back(mk(0, 1, 4'b0000, 1, (k < 3) ? 6'b001000 : 6'b010000, 0, 0, 0));
        for (int k = 0; k < 4; k++)
            q.push_back(mk(0, 1, 4'b0000, 0, 6'b010000, 0, 0, 0));
        step_mode = 1'b1;
        foreach (q[i]) begin
            reset = q[i].rst; run = q[i].run; opcode = q[i].op; step = q[i].stp;
            sb.push_back(q[i]);
            @(posedge clk); #1;
            e = sb.pop_front();
            n_cmp++;
            if (obs !== {e.t, e.lt, e.h, e.c}) begin
                n_bad++;
                $display("FAIL step[%0d]: got %b want %b", i, obs, {e.t, e.lt, e.h, e.c});
            end
        end
        step_mode = 1'b0;
        step = 1'b0;
    endtask
`endif

    initial begin
        reset  = 1'b1;
        run    = 1'b0;
        opcode = 4'b0000;
`ifdef TIMING_SINGLE_STEP_EN
        step      = 1'b0;
        step_mode = 1'b0;
`endif
        test_reset();
        test_mov();
        test_out();
        test_halt();
        test_run_hold();
        test_wrap_reset();
        test_back_to_back();
`ifdef TIMING_SINGLE_STEP_EN
        test_step();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/timing_generator.md
# timing_generator

Upstream T-state sequencer for the 8-bit CPU: it produces the one-hot timing strobes t0..t5 that the control unit decodes together with the instruction register opcode. It ends each instruction after the number of T states that opcode needs, stops on HALT, and counts retired instructions. It sits between the clock/reset source and the control unit.

## Interface
Parameters:
- CNT_W, 8, width of retired-instruction counter.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  reset, synchronous, active-high.
- run  input  1  advance enable; 0 holds the current T state.
- opcode  input  4  instruction register high nibble; valid from t3 onward.
- t0..t5  output  1 each  one-hot T-state strobes (at most one high).
- last_t  output  1  high during the final T state of the current instruction.
- halted  output  1  sticky HALT indication.
- instr_count  output  CNT_W  number of instructions retired.
- step, step_mode  input  1 each  present only with TIMING_SINGLE_STEP_EN; see Configuration.

## Operation
- State: 3-bit index T0..T5 plus `halted` flag; t-outputs are registered one-hot decodes of the index.
- Reset values: t0=1, t1..t5=0, halted=0, instr_count=0, last_t=0. The reset value of last_t holds because t0 is never final.
- Advance condition `adv` = run & ~halted (and the step qualifier when configured).
- Instruction length from opcode:
  - 0000 (MOV), 0011 (ADD), 0100 (SUB): 6 states, T0..T5, final T5.
  - 1110 (OUT) and all other non-HALT codes: 4 states, T0..T3, final T3.
  - 1111 (HALT): final T3.
- last_t is combinational: (T3 & opcode not in {0000, 0011, 0100}) | T5.
- On adv:
  - Not final: go to index+1.
  - Final, non-HALT: go to T0 and increment instr_count. The count wraps 2^CNT_W-1 -> 0.
  - Final T3 with opcode 1111: set halted=1 and drive all t outputs 0. instr_count increments (HALT retires). The index is frozen.
- Halted: t0..t5 all 0 and last_t=0 until reset. run and step are ignored.
- The length decision uses the opcode present in the final-candidate cycle. This is T3 for the 4/6 decision, and again T5, which is always final. A change in opcode during T4 has no effect.
- run=0 holds the index, the outputs, and instr_count unchanged. The strobe stays asserted, so the control unit re-applies the same micro-step; this behaviour is intended.
- Reset mid-instruction or while halted: the next cycle is T0 and the counter is cleared, regardless of run.

## Timing
- One T state per advancing clock; a strobe rises on the edge after its predecessor's cycle.
- Instruction latency with run held high: 6 cycles for MOV/ADD/SUB and 4 cycles for the others. The next instruction's t0 follows the final state with no bubble.
- HALT: t3 is high for exactly one cycle. On the next edge all strobes go low and halted=1.
- instr_count updates on the same edge that leaves the final state.
- No combinational path from opcode to t0..t5. The only combinational path is opcode to last_t.

## Configuration
- Macro TIMING_SINGLE_STEP_EN.
- Defined:
  - Ports step and step_mode exist.
  - step passes through a 2-flop synchronizer and a rising-edge detector, giving a one-cycle pulse 3 cycles after the edge.
  - When step_mode=1, adv additionally requires that pulse, so each step press advances exactly one T state. Holding step high gives exactly one advance.
  - When step_mode=0, behaviour is free-running as below.
  - The synchronizer flops reset to 0.
- Undefined: no step or step_mode ports and no synchronizer. adv = run & ~halted.

## Test plan
- Reset, run=1, opcode=0000 -> t0..t5 each high one cycle in order, back to t0 on cycle 7, instr_count=1, last_t high only in t5.
- opcode=1110, run=1 -> t0..t3 then t0; two instructions give 8 cycles and instr_count=2.
- opcode=1111 -> t3 for one cycle, then all t low and halted=1, instr_count=1. Further run=1 for 10 cycles gives no change. reset then gives t0=1, halted=0, count=0.
- run toggled 0 for 3 cycles during t2 of an ADD (0011) -> t2 held 4 cycles total, then t3..t5 continue, and the count increments once.
- instr_count preloaded by running 255 OUT instructions, then one more -> count wraps to 0. Reset asserted during t4 of a SUB -> t0 on the next cycle.
- With TIMING_SINGLE_STEP_EN and step_mode=1: three step pulses -> t3 reached, with 3 cycles of synchronizer latency per pulse. step held high for 20 cycles -> a single advance.
